// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one single-ported unified memory between the
// instruction fetch stage and the memory stage of the pipeline.
//
// Each access goes through IDLE (grant) -> ISSUE (one-cycle mem_en strobe)
// -> WAIT (until mem_done or timeout). The read data is registered and the
// owner's valid pulses for one cycle on the cycle after completion.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   if_req/if_addr           fetch read request (held until if_valid)
//   if_rdata/if_valid        fetch read data and one-cycle completion pulse
//   if_stall                 if_req & ~if_valid
//   dm_req/dm_wr/dm_addr/dm_wdata  memory-stage request (held until dm_valid)
//   dm_rdata/dm_valid        load data and one-cycle completion pulse
//   dm_stall                 dm_req & ~dm_valid
//   mem_en/mem_wr            one-cycle access strobe and write qualifier
//   mem_addr/mem_wdata       held stable from ISSUE until completion
//   mem_rdata/mem_done       memory read data and completion pulse
//   err                      sticky timeout flag
//
// Optional feature macro: ARB_FAIRNESS_EN
//   Defined: after STARVE_LIM consecutive data grants made while fetch was
//   waiting, the next grant goes to fetch. Undefined: strict data priority.

module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MAX_WAIT   = 15,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              dm_valid_q, dm_valid_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              err_q, err_d;

  logic              force_fetch_s;
  logic              grant_if_s;
  logic              grant_dm_s;
  logic              can_grant_s;

  // No grant while a completion pulse is out: the finished requester still
  // holds its req during that cycle and must not be served twice.
  assign can_grant_s = (state_q == IDLE) & ~if_valid_q & ~dm_valid_q;
  assign grant_if_s  = can_grant_s & if_req & (~dm_req | force_fetch_s);
  assign grant_dm_s  = can_grant_s & dm_req & ~grant_if_s;

`ifdef ARB_FAIRNESS_EN
  localparam int STV_W = $clog2(STARVE_LIM + 1);

  logic [STV_W-1:0] starve_q, starve_d;

  assign force_fetch_s = (starve_q == STV_W'(STARVE_LIM));

  // Starve counter: counts data grants made while fetch is waiting.
  always_comb begin
    starve_d = starve_q;
    if (grant_if_s) begin
      starve_d = '0;
    end else if (grant_dm_s && if_req && (starve_q != STV_W'(STARVE_LIM))) begin
      starve_d = starve_q + STV_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Starve counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_fetch_s = 1'b0;
`endif

  // Next-state and datapath logic for the access sequencer.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    mem_en_d    = 1'b0;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (grant_dm_s) begin
          owner_d     = OWN_DM;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_wr_d    = dm_wr;
          mem_en_d    = 1'b1;
          state_d     = ISSUE;
        end else if (grant_if_s) begin
          owner_d     = OWN_IF;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_wr_d    = 1'b0;
          mem_en_d    = 1'b1;
          state_d     = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_done) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (owner_q == OWN_DM) begin
            dm_valid_d = 1'b1;
            // Stores leave the load data register untouched.
            if (!mem_wr_q) begin
              dm_rdata_d = mem_rdata;
            end else begin
              dm_rdata_d = dm_rdata_q;
            end
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          // This is the MAX_WAIT-th WAIT cycle without mem_done: give up.
          state_d = IDLE;
          cnt_d   = CNT_W'(MAX_WAIT);
          err_d   = 1'b1;
          if (owner_q == OWN_DM) begin
            dm_valid_d = 1'b1;
            if (!mem_wr_q) begin
              dm_rdata_d = '0;
            end else begin
              dm_rdata_d = dm_rdata_q;
            end
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = '0;
          end
        end else if (cnt_q != CNT_W'(MAX_WAIT)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_valid  = dm_valid_q;
  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
  assign if_stall  = if_req & ~if_valid_q;
  assign dm_stall  = dm_req & ~dm_valid_q;

endmodule
